// File: rtl/pipe_skid_reg_pkg.sv
// Shared constants for the IF->ID skid buffer: ready levels, zero fill, depth limit.
package pipe_skid_reg_pkg;

  localparam logic AVAIL     = 1'b1;
  localparam logic UNAVAIL   = 1'b0;
  localparam logic ZERO_BIT  = 1'b0;
  localparam int   MAX_DEPTH = 4;

endpackage

// File: rtl/pipe_skid_reg.sv
// IF->ID pipeline buffer: small circular FIFO with registered in_ready,
// bubble (all-zero) output when empty, and flush that wins over push/pop.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready_q & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    in_ready_d = in_ready_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      in_ready_d = AVAIL;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // ready is decided from next-cycle occupancy, so a full buffer never
      // accepts in the same cycle it drains.
      in_ready_d = (count_d < FULL_CNT) ? AVAIL : UNAVAIL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= UNAVAIL;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= in_addr;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

  // Stale storage is never exposed: the head is masked by out_valid.
  assign out_addr = out_valid ? addr_mem[rd_ptr_q] : {ADDR_W{ZERO_BIT}};
  assign out_inst = out_valid ? inst_mem[rd_ptr_q] : {INST_W{ZERO_BIT}};
  assign in_ready = in_ready_q;
  assign count    = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: DEPTH=2 and DEPTH=3 instances share stimulus,
// checked against hand-written vectors and a queue model of each buffer.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_addr, in_inst;
  logic        rdy2, ov2, rdy3, ov3;
  logic [31:0] oa2, oi2, oa3, oi3;
  logic [1:0]  cnt2, cnt3;

  pipe_skid_reg #(.ADDR_W(32), .INST_W(32), .DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_addr(in_addr), .in_inst(in_inst), .out_valid(ov2), .out_ready(out_ready),
    .out_addr(oa2), .out_inst(oi2), .count(cnt2)
  );

  pipe_skid_reg #(.ADDR_W(32), .INST_W(32), .DEPTH(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy3),
    .in_addr(in_addr), .in_inst(in_inst), .out_valid(ov3), .out_ready(out_ready),
    .out_addr(oa3), .out_inst(oi3), .count(cnt3)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    bit          r, v;
    logic [31:0] a, i;
    bit          ordy, fl;
    logic [1:0]  e_cnt;
    bit          e_rdy;
    logic [31:0] e_addr, e_inst;
  } vec_t;

  ent_t        q2[$], q3[$];
  bit          m_rdy2 = 1'b0, m_rdy3 = 1'b0;
  bit          last_p3;
  logic [31:0] got3[$];
  int          n_cmp = 0, n_bad = 0;
  vec_t        vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_state();
    chk("d2.count", 32'(cnt2), 32'(q2.size()));
    chk("d2.out_valid", 32'(ov2), 32'(q2.size() > 0));
    chk("d2.in_ready", 32'(rdy2), 32'(m_rdy2));
    chk("d2.out_addr", oa2, (q2.size() > 0) ? q2[0].addr : 32'h0);
    chk("d2.out_inst", oi2, (q2.size() > 0) ? q2[0].inst : 32'h0);
    chk("d3.count", 32'(cnt3), 32'(q3.size()));
    chk("d3.out_valid", 32'(ov3), 32'(q3.size() > 0));
    chk("d3.in_ready", 32'(rdy3), 32'(m_rdy3));
    chk("d3.out_addr", oa3, (q3.size() > 0) ? q3[0].addr : 32'h0);
    chk("d3.out_inst", oi3, (q3.size() > 0) ? q3[0].inst : 32'h0);
  endtask

  // One clock: drive, compare popped heads, advance the models at the edge, check #1 later.
  task automatic step(input bit r, input bit v, input logic [31:0] a, input logic [31:0] i,
                      input bit ordy, input bit fl);
    bit   p2, p3, o2, o3;
    ent_t e;
    rst = r; in_valid = v; in_addr = a; in_inst = i; out_ready = ordy; flush = fl;
    p2 = !r && v && m_rdy2 && !fl;
    p3 = !r && v && m_rdy3 && !fl;
    o2 = !r && (q2.size() > 0) && ordy && !fl;
    o3 = !r && (q3.size() > 0) && ordy && !fl;
    #1;
    if (o2) begin
      chk("d2.pop_addr", oa2, q2[0].addr);
      chk("d2.pop_inst", oi2, q2[0].inst);
    end
    if (o3) begin
      chk("d3.pop_addr", oa3, q3[0].addr);
      chk("d3.pop_inst", oi3, q3[0].inst);
      got3.push_back(oa3);
    end
    @(posedge clk);
    e.addr = a;
    e.inst = i;
    if (r || fl) begin
      q2.delete();
      q3.delete();
    end else begin
      if (o2) void'(q2.pop_front());
      if (o3) void'(q3.pop_front());
      if (p2) q2.push_back(e);
      if (p3) q3.push_back(e);
    end
    m_rdy2  = !r && (q2.size() < 2);
    m_rdy3  = !r && (q3.size() < 3);
    last_p3 = p3;
    #1;
    check_state();
  endtask

  initial begin
    int k;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_addr = '0; in_inst = '0;

    // fields: r, v, addr, inst, out_ready, flush | DEPTH=2 expected: count, in_ready, out_addr, out_inst
    vt[0]  = '{1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,   32'h0};
    vt[1]  = '{1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,   32'h0};
    vt[2]  = '{1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,   32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 2'd0, 1'b1, 32'h0,   32'h0};
    vt[4]  = '{1'b0, 1'b1, 32'h100,  32'hA,    1'b1, 1'b0, 2'd1, 1'b1, 32'h100, 32'hA};
    vt[5]  = '{1'b0, 1'b1, 32'h104,  32'hB,    1'b1, 1'b0, 2'd1, 1'b1, 32'h104, 32'hB};
    vt[6]  = '{1'b0, 1'b1, 32'h108,  32'hC,    1'b1, 1'b0, 2'd1, 1'b1, 32'h108, 32'hC};
    vt[7]  = '{1'b0, 1'b1, 32'h10C,  32'hD,    1'b1, 1'b0, 2'd1, 1'b1, 32'h10C, 32'hD};
    vt[8]  = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 2'd0, 1'b1, 32'h0,   32'h0};
    vt[9]  = '{1'b0, 1'b1, 32'h200,  32'h20,   1'b0, 1'b0, 2'd1, 1'b1, 32'h200, 32'h20};
    vt[10] = '{1'b0, 1'b1, 32'h204,  32'h21,   1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h20};
    vt[11] = '{1'b0, 1'b1, 32'h208,  32'h22,   1'b0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h20};
    vt[12] = '{1'b0, 1'b1, 32'h208,  32'h22,   1'b1, 1'b0, 2'd1, 1'b1, 32'h204, 32'h21};
    vt[13] = '{1'b0, 1'b1, 32'h208,  32'h22,   1'b1, 1'b0, 2'd1, 1'b1, 32'h208, 32'h22};
    vt[14] = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 2'd1, 1'b1, 32'h208, 32'h22};
    vt[15] = '{1'b0, 1'b1, 32'h304,  32'h30,   1'b0, 1'b0, 2'd2, 1'b0, 32'h208, 32'h22};
    vt[16] = '{1'b0, 1'b1, 32'h300,  32'h31,   1'b1, 1'b1, 2'd0, 1'b1, 32'h0,   32'h0};
    vt[17] = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 2'd0, 1'b1, 32'h0,   32'h0};

    for (int n = 0; n < 18; n++) begin
      step(vt[n].r, vt[n].v, vt[n].a, vt[n].i, vt[n].ordy, vt[n].fl);
      chk($sformatf("vec%0d.count", n), 32'(cnt2), 32'(vt[n].e_cnt));
      chk($sformatf("vec%0d.in_ready", n), 32'(rdy2), 32'(vt[n].e_rdy));
      chk($sformatf("vec%0d.out_addr", n), oa2, vt[n].e_addr);
      chk($sformatf("vec%0d.out_inst", n), oi2, vt[n].e_inst);
      $display("vec %0d: count=%0d in_ready=%0b out_valid=%0b out_addr=%h out_inst=%h",
               n, cnt2, rdy2, ov2, oa2, oi2);
    end

    // Reset asserted mid-cycle with entries held: outputs must drop without a clock edge.
    step(1'b0, 1'b1, 32'h500, 32'h50, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h504, 32'h51, 1'b0, 1'b0);
    chk("midrst.pre_count", 32'(cnt2), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst.d2.out_valid", 32'(ov2), 32'd0);
    chk("midrst.d2.out_addr", oa2, 32'h0);
    chk("midrst.d2.count", 32'(cnt2), 32'd0);
    chk("midrst.d2.in_ready", 32'(rdy2), 32'd0);
    chk("midrst.d3.out_valid", 32'(ov3), 32'd0);
    chk("midrst.d3.out_inst", oi3, 32'h0);
    q2.delete(); q3.delete();
    m_rdy2 = 1'b0; m_rdy3 = 1'b0;
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Ten entries through DEPTH=3 with staggered out_ready to cross pointer wraps.
    got3.delete();
    k = 0;
    for (int c = 0; c < 200 && (k < 10 || q3.size() > 0); c++) begin
      step(1'b0, k < 10, 32'h400 + 32'(4 * k), 32'hF0 + 32'(k), (c % 7) >= 3, 1'b0);
      if (last_p3) k++;
    end
    chk("wrap.all_pushed", 32'(k), 32'd10);
    chk("wrap.drained", 32'(q3.size()), 32'd0);
    chk("wrap.pop_count", 32'(got3.size()), 32'd10);
    for (int j = 0; j < 10 && j < got3.size(); j++)
      chk($sformatf("wrap.order%0d", j), got3[j], 32'h400 + 32'(4 * j));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
